// File: rtl/lsu_axi_bridge.sv
// lsu_axi_bridge: turns single load/store requests into single-beat AXI4
// transactions. It builds write strobes, aligns store data onto byte lanes,
// and pulls load data off the bus with sign or zero extension. Misaligned
// requests are answered at once without touching the bus. Only one request
// is in flight at a time.
module lsu_axi_bridge #(
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ADDR_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    // request side
    input  logic                          req_valid_i,
    output logic                          req_ready_o,
    input  logic                          req_wen_i,
    input  logic [AXI_ADDR_WIDTH-1:0]     req_addr_i,
    input  logic [1:0]                    req_size_i,
    input  logic                          req_unsigned_i,
    input  logic [AXI_DATA_WIDTH-1:0]     req_wdata_i,
    // response side
    output logic                          resp_valid_o,
    input  logic                          resp_ready_i,
    output logic [AXI_DATA_WIDTH-1:0]     resp_rdata_o,
    output logic                          resp_misalign_o,
    // AXI AW
    output logic                          aw_valid_o,
    input  logic                          aw_ready_i,
    output logic [AXI_ADDR_WIDTH-1:0]     aw_addr_o,
    output logic [7:0]                    aw_len_o,
    output logic [2:0]                    aw_size_o,
    output logic [1:0]                    aw_burst_o,
    // AXI W
    output logic                          w_valid_o,
    input  logic                          w_ready_i,
    output logic [AXI_DATA_WIDTH-1:0]     w_data_o,
    output logic [AXI_DATA_WIDTH/8-1:0]   w_strb_o,
    output logic                          w_last_o,
    // AXI B
    input  logic                          b_valid_i,
    output logic                          b_ready_o,
    // AXI AR
    output logic                          ar_valid_o,
    input  logic                          ar_ready_i,
    output logic [AXI_ADDR_WIDTH-1:0]     ar_addr_o,
    output logic [7:0]                    ar_len_o,
    output logic [2:0]                    ar_size_o,
    output logic [1:0]                    ar_burst_o,
    // AXI R
    input  logic                          r_valid_i,
    output logic                          r_ready_o,
    input  logic [AXI_DATA_WIDTH-1:0]     r_data_i,
    input  logic                          r_last_i
);

    localparam int STRB_W = AXI_DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AR,
        ST_R,
        ST_WR,
        ST_B,
        ST_RESP
    } state_t;

    state_t state_q, state_d;

    logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [1:0]                size_q, size_d;
    logic                      unsigned_q, unsigned_d;
    logic [AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0]         wstrb_q, wstrb_d;
    logic [AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                      misalign_q, misalign_d;
    logic                      ar_valid_q, ar_valid_d;
    logic                      aw_valid_q, aw_valid_d;
    logic                      w_valid_q, w_valid_d;
    logic                      aw_done_q, aw_done_d;
    logic                      w_done_q, w_done_d;
    logic                      r_ready_q, r_ready_d;
    logic                      b_ready_q, b_ready_d;
    logic                      resp_valid_q, resp_valid_d;

    logic                      req_misaligned;
    logic [STRB_W-1:0]         strb_base;
    logic [AXI_DATA_WIDTH-1:0] rd_shifted;
    logic [AXI_DATA_WIDTH-1:0] rd_ext;

    // Single-beat transactions never need the last flag.
    logic unused_r_last;
    assign unused_r_last = r_last_i;

    // Alignment check and strobe pattern for the incoming request.
    always_comb begin
        req_misaligned = 1'b0;
        strb_base      = '0;
        unique case (req_size_i)
            2'd0: begin
                req_misaligned = 1'b0;
                strb_base      = STRB_W'(8'h01);
            end
            2'd1: begin
                req_misaligned = req_addr_i[0];
                strb_base      = STRB_W'(8'h03);
            end
            2'd2: begin
                req_misaligned = |req_addr_i[1:0];
                strb_base      = STRB_W'(8'h0F);
            end
            default: begin
                req_misaligned = |req_addr_i[2:0];
                strb_base      = STRB_W'(8'hFF);
            end
        endcase
    end

    // Shift the read beat down to the addressed lane and extend to full width.
    always_comb begin
        rd_shifted = r_data_i >> {addr_q[2:0], 3'b000};
        rd_ext     = rd_shifted;
        unique case (size_q)
            2'd0: rd_ext = unsigned_q ? {{(AXI_DATA_WIDTH-8){1'b0}}, rd_shifted[7:0]}
                                      : {{(AXI_DATA_WIDTH-8){rd_shifted[7]}}, rd_shifted[7:0]};
            2'd1: rd_ext = unsigned_q ? {{(AXI_DATA_WIDTH-16){1'b0}}, rd_shifted[15:0]}
                                      : {{(AXI_DATA_WIDTH-16){rd_shifted[15]}}, rd_shifted[15:0]};
            2'd2: rd_ext = unsigned_q ? {{(AXI_DATA_WIDTH-32){1'b0}}, rd_shifted[31:0]}
                                      : {{(AXI_DATA_WIDTH-32){rd_shifted[31]}}, rd_shifted[31:0]};
            default: rd_ext = rd_shifted;
        endcase
    end

    // Next-state and next-output logic; every output flop has its _d here.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        size_d       = size_q;
        unsigned_d   = unsigned_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        rdata_d      = rdata_q;
        misalign_d   = misalign_q;
        ar_valid_d   = ar_valid_q;
        aw_valid_d   = aw_valid_q;
        w_valid_d    = w_valid_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;
        r_ready_d    = r_ready_q;
        b_ready_d    = b_ready_q;
        resp_valid_d = resp_valid_q;

        unique case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    addr_d     = req_addr_i;
                    size_d     = req_size_i;
                    unsigned_d = req_unsigned_i;
                    if (req_misaligned) begin
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        misalign_d   = 1'b1;
                        rdata_d      = '0;
                    end else if (req_wen_i) begin
                        state_d    = ST_WR;
                        aw_valid_d = 1'b1;
                        w_valid_d  = 1'b1;
                        aw_done_d  = 1'b0;
                        w_done_d   = 1'b0;
                        wdata_d    = req_wdata_i << {req_addr_i[2:0], 3'b000};
                        wstrb_d    = strb_base << req_addr_i[2:0];
                        rdata_d    = '0;
                    end else begin
                        state_d    = ST_AR;
                        ar_valid_d = 1'b1;
                    end
                end
            end
            ST_AR: begin
                if (ar_ready_i) begin
                    state_d    = ST_R;
                    ar_valid_d = 1'b0;
                    r_ready_d  = 1'b1;
                end
            end
            ST_R: begin
                if (r_valid_i) begin
                    state_d      = ST_RESP;
                    r_ready_d    = 1'b0;
                    rdata_d      = rd_ext;
                    misalign_d   = 1'b0;
                    resp_valid_d = 1'b1;
                end
            end
            ST_WR: begin
                // Done flags include this cycle's handshakes so that AW and W
                // completing together still move on in one step.
                aw_done_d = aw_done_q | (aw_valid_q & aw_ready_i);
                w_done_d  = w_done_q | (w_valid_q & w_ready_i);
                if (aw_valid_q && aw_ready_i) aw_valid_d = 1'b0;
                if (w_valid_q && w_ready_i)   w_valid_d  = 1'b0;
                if (aw_done_d && w_done_d) begin
                    state_d   = ST_B;
                    b_ready_d = 1'b1;
                end
            end
            ST_B: begin
                if (b_valid_i) begin
                    state_d      = ST_RESP;
                    b_ready_d    = 1'b0;
                    misalign_d   = 1'b0;
                    resp_valid_d = 1'b1;
                end
            end
            ST_RESP: begin
                if (resp_ready_i) begin
                    state_d      = ST_IDLE;
                    resp_valid_d = 1'b0;
                    misalign_d   = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            size_q       <= '0;
            unsigned_q   <= 1'b0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            rdata_q      <= '0;
            misalign_q   <= 1'b0;
            ar_valid_q   <= 1'b0;
            aw_valid_q   <= 1'b0;
            w_valid_q    <= 1'b0;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            r_ready_q    <= 1'b0;
            b_ready_q    <= 1'b0;
            resp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            size_q       <= size_d;
            unsigned_q   <= unsigned_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            rdata_q      <= rdata_d;
            misalign_q   <= misalign_d;
            ar_valid_q   <= ar_valid_d;
            aw_valid_q   <= aw_valid_d;
            w_valid_q    <= w_valid_d;
            aw_done_q    <= aw_done_d;
            w_done_q     <= w_done_d;
            r_ready_q    <= r_ready_d;
            b_ready_q    <= b_ready_d;
            resp_valid_q <= resp_valid_d;
        end
    end

    assign req_ready_o     = (state_q == ST_IDLE);
    assign resp_valid_o    = resp_valid_q;
    assign resp_rdata_o    = rdata_q;
    assign resp_misalign_o = misalign_q;

    assign aw_valid_o = aw_valid_q;
    assign aw_addr_o  = addr_q;
    assign aw_len_o   = 8'd0;
    assign aw_size_o  = {1'b0, size_q};
    assign aw_burst_o = 2'b01;

    assign w_valid_o = w_valid_q;
    assign w_data_o  = wdata_q;
    assign w_strb_o  = wstrb_q;
    assign w_last_o  = 1'b1;

    assign b_ready_o = b_ready_q;

    assign ar_valid_o = ar_valid_q;
    assign ar_addr_o  = addr_q;
    assign ar_len_o   = 8'd0;
    assign ar_size_o  = {1'b0, size_q};
    assign ar_burst_o = 2'b01;

    assign r_ready_o = r_ready_q;

endmodule
